rs_issue_sched: RTL and testbench
=================================

RS_ISSUE_SCHED -- requirements
Module: rs_issue_sched

Interface
REQ-001 The block SHALL have parameter RS_SZ, default 16, meaning number of RS entries.
REQ-002 The block SHALL have parameter N, default 2, meaning superscalar issue width.
REQ-003 The block SHALL have parameter MULT_LAT, default 4, meaning cycles the non-pipelined multiplier stays occupied per issue.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port rs_valid, input, RS_SZ bits: entry holds a live instruction.
REQ-007 The block SHALL have port rs_ready, input, RS_SZ bits: both sources of the entry are ready.
REQ-008 The block SHALL have port rs_is_mult, input, RS_SZ bits: entry needs the multiplier.
REQ-009 The block SHALL have port b_mm_mispred, input, 1 bit: a branch mispredict resolves this cycle.
REQ-010 The block SHALL have port mult_kill, input, 1 bit: the in-flight multiply is squashed.
REQ-011 The block SHALL have port stall, input, 1 bit: the issue register cannot accept this cycle.
REQ-012 The block SHALL have port rs_data_issuing, output, RS_SZ bits: grant vector to the RS.
REQ-013 The block SHALL have port num_issuing, output, $clog2(N+1) bits: popcount of rs_data_issuing.
REQ-014 The block SHALL have port mult_busy, output, 1 bit: the multiplier is occupied.

Function
REQ-015 eligible[i] SHALL be rs_valid[i] & rs_ready[i] & (~rs_is_mult[i] | ~mult_busy).
REQ-016 rs_data_issuing SHALL be combinational from the inputs and registered state, with zero-cycle latency to the RS.
REQ-017 The grant scan SHALL start at index ptr, ascend modulo RS_SZ, and pick the first N eligible entries.
REQ-018 A single cycle SHALL grant at most one entry with rs_is_mult set; further mult entries are skipped and the scan continues.
REQ-019 When stall or b_mm_mispred is 1, rs_data_issuing SHALL be all zero and num_issuing SHALL be 0.
REQ-020 num_issuing SHALL always equal the popcount of rs_data_issuing, which never exceeds N.
REQ-021 The multiplier FSM SHALL have two states, IDLE and BUSY, with a counter of $clog2(MULT_LAT+1) bits.
REQ-022 IDLE SHALL move to BUSY when a mult is granted, with the counter loaded to MULT_LAT-1.
REQ-023 In BUSY the counter SHALL decrement every cycle, regardless of stall.
REQ-024 BUSY SHALL move to IDLE on the edge at which the counter is 0.
REQ-025 mult_busy SHALL equal (state==BUSY).
REQ-026 mult_kill SHALL force the FSM to IDLE and the counter to 0 on the next edge, with priority over every other transition.
REQ-027 With MULT_LAT=1, a granted mult SHALL block mult grants for exactly one following cycle.
REQ-028 ptr SHALL update on a cycle with num_issuing>0 to (highest-scan-order granted index + 1) mod RS_SZ.
REQ-029 ptr SHALL hold on a cycle with num_issuing==0.
REQ-030 A grant at index RS_SZ-1 SHALL wrap ptr to 0.
REQ-031 With no eligible entries, the block SHALL produce zero grants and change no state except the counter.

Reset
REQ-032 While reset is 1, the block SHALL hold ptr=0, FSM=IDLE, counter=0, mult_busy=0, and force rs_data_issuing=0 and num_issuing=0.
REQ-033 A reset asserted mid-multiply SHALL abandon the multiply immediately.
REQ-034 In the first cycle after reset release, the block SHALL grant normally from ptr=0.

Configuration
REQ-035 With RS_SCHED_RR_EN defined, ptr SHALL rotate as per REQ-028 to REQ-030.
REQ-036 With RS_SCHED_RR_EN undefined, ptr SHALL be constant 0, giving fixed lowest-index-first priority, and the ptr register SHALL be absent.

Verification (RS_SZ=16, N=2, MULT_LAT=4)
REQ-037 Case ptr=0, entries 3, 7, 9 eligible, no mult: the bench SHALL see rs_data_issuing=0x0088, num_issuing=2, and ptr=8 next cycle.
REQ-038 Case entries 2 and 5 both mult and ready, multiplier idle: the bench SHALL see only entry 2 granted, mult_busy=1 for 4 cycles, and entry 5 granted in the cycle after mult_busy falls.
REQ-039 Case ptr=14, entries 15 and 1 eligible: the bench SHALL see grant 0x8002 and ptr=2; without RS_SCHED_RR_EN the grant is the same and ptr stays 0.
REQ-040 Case stall=1 or b_mm_mispred=1 with 4 eligible entries: the bench SHALL see grant 0 and ptr unchanged.
REQ-041 Case mult_kill one cycle after a mult grant: the bench SHALL see mult_busy=0 on the next cycle and a waiting mult granted.
REQ-042 Case reset asserted asynchronously mid-BUSY: the bench SHALL see mult_busy=0 and grant 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rs_issue_sched.sv
// rs_issue_sched: picks up to N ready RS entries per cycle, at most one multiply, with a non-pipelined multiplier busy tracker.
// Define RS_SCHED_RR_EN for a rotating scan start; otherwise the lowest index always wins.
module rs_issue_sched #(
    parameter int RS_SZ    = 16,
    parameter int N        = 2,
    parameter int MULT_LAT = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [RS_SZ-1:0]           rs_valid,
    input  logic [RS_SZ-1:0]           rs_ready,
    input  logic [RS_SZ-1:0]           rs_is_mult,
    input  logic                       b_mm_mispred,
    input  logic                       mult_kill,
    input  logic                       stall,
    output logic [RS_SZ-1:0]           rs_data_issuing,
    output logic [$clog2(N+1)-1:0]     num_issuing,
    output logic                       mult_busy
);
    localparam int PW = (RS_SZ > 1) ? $clog2(RS_SZ) : 1;
    localparam int NW = $clog2(N + 1);
    localparam int CW = $clog2(MULT_LAT + 1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [RS_SZ-1:0] elig, grant;
    logic [PW-1:0]   ptr, idx;
    logic            blk, mult_taken, mult_grant;
    int              n_g;
    assign mult_busy = (state == BUSY);
    assign elig = rs_valid & rs_ready & (~rs_is_mult | {RS_SZ{~mult_busy}});
    assign blk = stall | b_mm_mispred | reset;
    // Rotating scan from ptr; a second multiply in the same cycle is skipped, not a scan stop.
    always_comb begin
        grant = '0;
        mult_taken = 1'b0;
        n_g = 0;
        idx = '0;
        for (int k = 0; k < RS_SZ; k++) begin
            idx = PW'((int'(ptr) + k) % RS_SZ);
            if (!blk && elig[idx] && n_g < N && !(rs_is_mult[idx] && mult_taken)) begin
                grant[idx] = 1'b1;
                n_g = n_g + 1;
                mult_taken = mult_taken | rs_is_mult[idx];
            end
        end
    end
    assign rs_data_issuing = grant;
    assign num_issuing = NW'($countones(grant));
    assign mult_grant = |(grant & rs_is_mult);
`ifdef RS_SCHED_RR_EN
    logic [PW-1:0] last;
    always_comb begin
        last = ptr;
        for (int k = 0; k < RS_SZ; k++) begin
            if (grant[PW'((int'(ptr) + k) % RS_SZ)]) last = PW'((int'(ptr) + k) % RS_SZ);
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ptr <= '0;
        else if (|grant) ptr <= (last == PW'(RS_SZ - 1)) ? '0 : last + 1'b1;
    end
`else
    assign ptr = '0;
`endif
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
        end
    end
    // Kill beats everything; the counter runs down in BUSY independent of stall.
    always_comb begin
        state_n = mult_kill ? IDLE : (state == IDLE) ? (mult_grant ? BUSY : IDLE) : (cnt == '0) ? IDLE : BUSY;
        cnt_n = mult_kill ? '0 : (state == IDLE) ? (mult_grant ? CW'(MULT_LAT - 1) : cnt) : (cnt == '0) ? '0 : cnt - 1'b1;
    end
endmodule

// File: tb/tb_rs_issue_sched.sv
// tb_rs_issue_sched: directed scoreboard bench for rs_issue_sched (RS_SZ=16, N=2, MULT_LAT=4).
module tb_rs_issue_sched;
`ifdef RS_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic        clock, reset, b_mm_mispred, mult_kill, stall, mult_busy;
    logic [15:0] rs_valid, rs_ready, rs_is_mult, rs_data_issuing;
    logic [1:0]  num_issuing;
    int          total = 0;
    int          bad = 0;
    typedef struct packed {
        logic [15:0] g;
        logic [1:0]  n;
        logic        b;
    } exp_t;
    exp_t  sb_q[$];
    string tag_q[$];

    rs_issue_sched #(.RS_SZ(16), .N(2), .MULT_LAT(4)) dut (
        .clock(clock), .reset(reset), .rs_valid(rs_valid), .rs_ready(rs_ready),
        .rs_is_mult(rs_is_mult), .b_mm_mispred(b_mm_mispred), .mult_kill(mult_kill),
        .stall(stall), .rs_data_issuing(rs_data_issuing), .num_issuing(num_issuing),
        .mult_busy(mult_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check();
        exp_t  e;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        total++;
        assert (rs_data_issuing === e.g) else begin
            bad++;
            $error("FAIL %s grant got=%h exp=%h", t, rs_data_issuing, e.g);
        end
        total++;
        assert (num_issuing === e.n) else begin
            bad++;
            $error("FAIL %s num got=%0d exp=%0d", t, num_issuing, e.n);
        end
        total++;
        assert (mult_busy === e.b) else begin
            bad++;
            $error("FAIL %s busy got=%b exp=%b", t, mult_busy, e.b);
        end
    endtask

    // Called at a falling edge: drive, record expectation, sample 1ns later, move to next falling edge.
    task automatic step(input string tag, input logic r, input logic [15:0] v, input logic [15:0] rd,
                        input logic [15:0] m, input logic s, input logic p, input logic k,
                        input logic [15:0] eg, input logic eb);
        reset = r;
        rs_valid = v;
        rs_ready = rd;
        rs_is_mult = m;
        stall = s;
        b_mm_mispred = p;
        mult_kill = k;
        sb_q.push_back('{eg, 2'($countones(eg)), eb});
        tag_q.push_back(tag);
        #1;
        check();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        rs_valid = '0;
        rs_ready = '0;
        rs_is_mult = '0;
        stall = 1'b0;
        b_mm_mispred = 1'b0;
        mult_kill = 1'b0;
        @(negedge clock);
        step("in_reset",   1, 16'hffff, 16'hffff, 16'h0000, 0, 0, 0, 16'h0000, 0);
        step("first_scan", 0, 16'h0288, 16'h0288, 16'h0000, 0, 0, 0, 16'h0088, 0);
        step("rotate",     0, 16'h0288, 16'h0288, 16'h0000, 0, 0, 0, RR ? 16'h0208 : 16'h0088, 0);
        step("single13",   0, 16'h2000, 16'h2000, 16'h0000, 0, 0, 0, 16'h2000, 0);
        step("wrap_scan",  0, 16'h8002, 16'h8002, 16'h0000, 0, 0, 0, 16'h8002, 0);
        step("top_entry",  0, 16'h8000, 16'h8000, 16'h0000, 0, 0, 0, 16'h8000, 0);
        step("after_wrap", 0, 16'h000a, 16'h000a, 16'h0000, 0, 0, 0, 16'h000a, 0);
        step("stall",      0, 16'h0065, 16'h0065, 16'h0000, 1, 0, 0, 16'h0000, 0);
        step("mispred",    0, 16'h0065, 16'h0065, 16'h0000, 0, 1, 0, 16'h0000, 0);
        step("post_stall", 0, 16'h0065, 16'h0065, 16'h0000, 0, 0, 0, RR ? 16'h0060 : 16'h0005, 0);
        step("two_mults",  0, 16'h0024, 16'h0024, 16'h0024, 0, 0, 0, 16'h0004, 0);
        step("busy1",      0, 16'h0020, 16'h0020, 16'h0020, 0, 0, 0, 16'h0000, 1);
        step("busy2",      0, 16'h0020, 16'h0020, 16'h0020, 1, 0, 0, 16'h0000, 1);
        step("busy3",      0, 16'h0020, 16'h0020, 16'h0020, 0, 0, 0, 16'h0000, 1);
        step("busy4",      0, 16'h0020, 16'h0020, 16'h0020, 0, 0, 0, 16'h0000, 1);
        step("mult5",      0, 16'h0020, 16'h0020, 16'h0020, 0, 0, 0, 16'h0020, 0);
        step("kill",       0, 16'h0100, 16'h0100, 16'h0100, 0, 0, 1, 16'h0000, 1);
        step("after_kill", 0, 16'h0100, 16'h0100, 16'h0100, 0, 0, 0, 16'h0100, 0);
        step("busy_mixed", 0, 16'h0c00, 16'h0c00, 16'h0400, 0, 0, 0, 16'h0800, 1);
        step("async_rst",  1, 16'h0003, 16'h0003, 16'h0000, 0, 0, 0, 16'h0000, 0);
        step("post_rst",   0, 16'h0013, 16'h0013, 16'h0010, 0, 0, 0, 16'h0003, 0);
        step("mult_skip",  0, 16'h0248, 16'h0248, 16'h0048, 0, 0, 0, 16'h0208, 0);
        step("none_ready", 0, 16'h00ff, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
